// File: rtl/rv32_regfile_pkg.sv
// Shared widths, register count and index/data types for the RV32I register file.
package rv32_regfile_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 5;
    localparam int unsigned NUM_REGS   = 2 ** ADDR_WIDTH;
    localparam int unsigned ZERO_REG   = 0;

    typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [DATA_WIDTH-1:0] reg_data_t;

endpackage

// File: rtl/rv32_register_file_if.sv
// Decode/writeback bus of the register file: two read ports and one write port.
interface rv32_register_file_if #(
    parameter int unsigned DATA_WIDTH = rv32_regfile_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = rv32_regfile_pkg::ADDR_WIDTH
);

    logic [ADDR_WIDTH-1:0] r1Address;
    logic [ADDR_WIDTH-1:0] r2Address;
    logic [DATA_WIDTH-1:0] r1Data;
    logic [DATA_WIDTH-1:0] r2Data;
    logic                  writeRegister;
    logic [ADDR_WIDTH-1:0] writeAddress;
    logic [DATA_WIDTH-1:0] writeData;

    modport master (
        output r1Address, r2Address, writeRegister, writeAddress, writeData,
        input  r1Data, r2Data
    );

    modport slave (
        input  r1Address, r2Address, writeRegister, writeAddress, writeData,
        output r1Data, r2Data
    );

endinterface

// File: rtl/rv32_regfile_read_port.sv
// One combinational read port: x0 forced to zero, optional same-cycle write bypass
// when REGFILE_WRITE_BYPASS_EN is defined.
module rv32_regfile_read_port #(
    parameter int unsigned DATA_WIDTH = rv32_regfile_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = rv32_regfile_pkg::ADDR_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0]                            addr,
    input  logic [(1 << ADDR_WIDTH)-1:0][DATA_WIDTH-1:0]     regs,
`ifdef REGFILE_WRITE_BYPASS_EN
    input  logic                                             reset,
    input  logic                                             write_en,
    input  logic [ADDR_WIDTH-1:0]                            write_addr,
    input  logic [DATA_WIDTH-1:0]                            write_data,
`endif
    output logic [DATA_WIDTH-1:0]                            data
);

    import rv32_regfile_pkg::*;

    always_comb begin
        data = regs[addr];
`ifdef REGFILE_WRITE_BYPASS_EN
        if (write_en && !reset && (write_addr != ADDR_WIDTH'(ZERO_REG)) && (write_addr == addr)) begin
            data = write_data;
        end
`endif
        if (addr == ADDR_WIDTH'(ZERO_REG)) begin
            data = '0;
        end
    end

endmodule

// File: rtl/rv32_register_file.sv
// RV32I integer register file: 2 combinational reads, 1 synchronous write, x0 hardwired.
// Optional same-cycle write bypass on the read ports: REGFILE_WRITE_BYPASS_EN.
module rv32_register_file #(
    parameter int unsigned DATA_WIDTH = rv32_regfile_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = rv32_regfile_pkg::ADDR_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    rv32_register_file_if.slave  rf
);

    import rv32_regfile_pkg::*;

    localparam int unsigned NumRegs = 1 << ADDR_WIDTH;

    logic [NumRegs-1:0][DATA_WIDTH-1:0] regs;

    // Entry 0 has no storage at all, so no write path can ever reach it.
    assign regs[ZERO_REG] = '0;

    for (genvar i = 1; i < NumRegs; i++) begin : g_regs
        logic [DATA_WIDTH-1:0] data_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                data_q <= '0;
            end else if (rf.writeRegister && (rf.writeAddress == ADDR_WIDTH'(i))) begin
                data_q <= rf.writeData;
            end
        end

        assign regs[i] = data_q;
    end

    rv32_regfile_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_read_port1 (
        .addr       (rf.r1Address),
        .regs       (regs),
`ifdef REGFILE_WRITE_BYPASS_EN
        .reset      (reset),
        .write_en   (rf.writeRegister),
        .write_addr (rf.writeAddress),
        .write_data (rf.writeData),
`endif
        .data       (rf.r1Data)
    );

    rv32_regfile_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_read_port2 (
        .addr       (rf.r2Address),
        .regs       (regs),
`ifdef REGFILE_WRITE_BYPASS_EN
        .reset      (reset),
        .write_en   (rf.writeRegister),
        .write_addr (rf.writeAddress),
        .write_data (rf.writeData),
`endif
        .data       (rf.r2Data)
    );

endmodule

// File: tb/tb_rv32_register_file.sv
// Scoreboard bench for rv32_register_file; expectations follow REGFILE_WRITE_BYPASS_EN.
module tb_rv32_register_file;

    typedef struct {
        logic [31:0] r1;
        logic [31:0] r2;
    } exp_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    logic [31:0] model [32];
    exp_t        sb_q [$];

    rv32_register_file_if rf_if ();

    rv32_register_file dut (
        .clk   (clk),
        .reset (reset),
        .rf    (rf_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected read value given the currently driven write port and the model.
    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
`ifdef REGFILE_WRITE_BYPASS_EN
        if (rf_if.writeRegister && !reset && (rf_if.writeAddress == a)) return rf_if.writeData;
`endif
        return model[a];
    endfunction

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        rf_if.writeRegister = 1'b1;
        rf_if.writeAddress  = a;
        rf_if.writeData     = d;
        @(posedge clk);
        #1;
        rf_if.writeRegister = 1'b0;
        if (!reset && a != 5'd0) model[a] = d;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int i = 1; i < 32; i++) do_write(5'(i), 32'(i) * 32'h0101_0101 ^ 32'hA5A5_0000);
        @(negedge clk);
        #2;
        reset = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        for (int a = 0; a < 32; a++) begin
            rf_if.r1Address = 5'(a);
            rf_if.r2Address = 5'(31 - a);
            sb_q.push_back('{32'h0, 32'h0});
            #1;
            e = sb_q.pop_front();
            total += 2;
            if (rf_if.r1Data !== e.r1) begin
                bad++;
                $display("FAIL reset_hold r1 addr=%0d got=%h want=%h", a, rf_if.r1Data, e.r1);
            end
            if (rf_if.r2Data !== e.r2) begin
                bad++;
                $display("FAIL reset_hold r2 addr=%0d got=%h want=%h", 31 - a, rf_if.r2Data, e.r2);
            end
        end
        // A write presented while reset is high must be discarded.
        rf_if.writeRegister = 1'b1;
        rf_if.writeAddress  = 5'd3;
        rf_if.writeData     = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        rf_if.writeRegister = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int a = 0; a < 32; a++) begin
            rf_if.r1Address = 5'(a);
            rf_if.r2Address = 5'(a);
            sb_q.push_back('{32'h0, 32'h0});
            #1;
            e = sb_q.pop_front();
            total += 2;
            if (rf_if.r1Data !== e.r1) begin
                bad++;
                $display("FAIL reset_after r1 addr=%0d got=%h want=%h", a, rf_if.r1Data, e.r1);
            end
            if (rf_if.r2Data !== e.r2) begin
                bad++;
                $display("FAIL reset_after r2 addr=%0d got=%h want=%h", a, rf_if.r2Data, e.r2);
            end
        end
    endtask

    task automatic test_write_read();
        exp_t e;
        do_write(5'd5, 32'h0000_00FF);
        rf_if.r1Address = 5'd5;
        rf_if.r2Address = 5'd6;
        sb_q.push_back('{32'h0000_00FF, 32'h0});
        #1;
        e = sb_q.pop_front();
        total += 2;
        if (rf_if.r1Data !== e.r1) begin
            bad++;
            $display("FAIL write_read r1 got=%h want=%h", rf_if.r1Data, e.r1);
        end
        if (rf_if.r2Data !== e.r2) begin
            bad++;
            $display("FAIL write_read r2 got=%h want=%h", rf_if.r2Data, e.r2);
        end
    endtask

    task automatic test_dual_read();
        exp_t e;
        do_write(5'd10, 32'h8888_8888);
        rf_if.r1Address = 5'd5;
        rf_if.r2Address = 5'd10;
        sb_q.push_back('{32'h0000_00FF, 32'h8888_8888});
        #1;
        e = sb_q.pop_front();
        total += 2;
        if (rf_if.r1Data !== e.r1) begin
            bad++;
            $display("FAIL dual_read r1 got=%h want=%h", rf_if.r1Data, e.r1);
        end
        if (rf_if.r2Data !== e.r2) begin
            bad++;
            $display("FAIL dual_read r2 got=%h want=%h", rf_if.r2Data, e.r2);
        end
        rf_if.r1Address = 5'd10;
        sb_q.push_back('{32'h8888_8888, 32'h8888_8888});
        #1;
        e = sb_q.pop_front();
        total += 2;
        if (rf_if.r1Data !== e.r1) begin
            bad++;
            $display("FAIL same_reg r1 got=%h want=%h", rf_if.r1Data, e.r1);
        end
        if (rf_if.r2Data !== e.r2) begin
            bad++;
            $display("FAIL same_reg r2 got=%h want=%h", rf_if.r2Data, e.r2);
        end
    endtask

    task automatic test_x0();
        exp_t e;
        do_write(5'd0, 32'h1111_1111);
        rf_if.r1Address = 5'd0;
        rf_if.r2Address = 5'd0;
        sb_q.push_back('{32'h0, 32'h0});
        #1;
        e = sb_q.pop_front();
        total += 2;
        if (rf_if.r1Data !== e.r1) begin
            bad++;
            $display("FAIL x0 r1 got=%h want=%h", rf_if.r1Data, e.r1);
        end
        if (rf_if.r2Data !== e.r2) begin
            bad++;
            $display("FAIL x0 r2 got=%h want=%h", rf_if.r2Data, e.r2);
        end
    endtask

    task automatic test_write_disable();
        exp_t e;
        @(negedge clk);
        rf_if.writeRegister = 1'b0;
        rf_if.writeAddress  = 5'd5;
        rf_if.writeData     = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        rf_if.r1Address = 5'd5;
        rf_if.r2Address = 5'd5;
        sb_q.push_back('{32'h0000_00FF, 32'h0000_00FF});
        #1;
        e = sb_q.pop_front();
        total += 2;
        if (rf_if.r1Data !== e.r1) begin
            bad++;
            $display("FAIL write_disable r1 got=%h want=%h", rf_if.r1Data, e.r1);
        end
        if (rf_if.r2Data !== e.r2) begin
            bad++;
            $display("FAIL write_disable r2 got=%h want=%h", rf_if.r2Data, e.r2);
        end
    endtask

    task automatic test_bypass();
        exp_t e;
        @(negedge clk);
        rf_if.writeRegister = 1'b1;
        rf_if.writeAddress  = 5'd7;
        rf_if.writeData     = 32'hCAFE_F00D;
        rf_if.r1Address     = 5'd7;
        rf_if.r2Address     = 5'd10;
`ifdef REGFILE_WRITE_BYPASS_EN
        sb_q.push_back('{32'hCAFE_F00D, 32'h8888_8888});
`else
        sb_q.push_back('{32'h0, 32'h8888_8888});
`endif
        #1;
        e = sb_q.pop_front();
        total += 2;
        if (rf_if.r1Data !== e.r1) begin
            bad++;
            $display("FAIL bypass_pre r1 got=%h want=%h", rf_if.r1Data, e.r1);
        end
        if (rf_if.r2Data !== e.r2) begin
            bad++;
            $display("FAIL bypass_pre r2 got=%h want=%h", rf_if.r2Data, e.r2);
        end
        @(posedge clk);
        #1;
        rf_if.writeRegister = 1'b0;
        model[7] = 32'hCAFE_F00D;
        sb_q.push_back('{32'hCAFE_F00D, 32'h8888_8888});
        #1;
        e = sb_q.pop_front();
        total += 2;
        if (rf_if.r1Data !== e.r1) begin
            bad++;
            $display("FAIL bypass_post r1 got=%h want=%h", rf_if.r1Data, e.r1);
        end
        if (rf_if.r2Data !== e.r2) begin
            bad++;
            $display("FAIL bypass_post r2 got=%h want=%h", rf_if.r2Data, e.r2);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            rf_if.writeRegister = ($urandom_range(0, 3) != 0);
            rf_if.writeAddress  = 5'($urandom_range(0, 31));
            rf_if.writeData     = $urandom;
            rf_if.r1Address     = rf_if.writeAddress;
            rf_if.r2Address     = 5'($urandom_range(0, 31));
            sb_q.push_back('{exp_read(rf_if.r1Address), exp_read(rf_if.r2Address)});
            #1;
            e = sb_q.pop_front();
            total += 2;
            if (rf_if.r1Data !== e.r1) begin
                bad++;
                $display("FAIL b2b_pre r1 n=%0d got=%h want=%h", n, rf_if.r1Data, e.r1);
            end
            if (rf_if.r2Data !== e.r2) begin
                bad++;
                $display("FAIL b2b_pre r2 n=%0d got=%h want=%h", n, rf_if.r2Data, e.r2);
            end
            @(posedge clk);
            #1;
            if (rf_if.writeRegister && rf_if.writeAddress != 5'd0)
                model[rf_if.writeAddress] = rf_if.writeData;
            rf_if.writeRegister = 1'b0;
            sb_q.push_back('{exp_read(rf_if.r1Address), exp_read(rf_if.r2Address)});
            #1;
            e = sb_q.pop_front();
            total += 2;
            if (rf_if.r1Data !== e.r1) begin
                bad++;
                $display("FAIL b2b_post r1 n=%0d got=%h want=%h", n, rf_if.r1Data, e.r1);
            end
            if (rf_if.r2Data !== e.r2) begin
                bad++;
                $display("FAIL b2b_post r2 n=%0d got=%h want=%h", n, rf_if.r2Data, e.r2);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        reset               = 1'b1;
        rf_if.r1Address     = 5'd0;
        rf_if.r2Address     = 5'd0;
        rf_if.writeRegister = 1'b0;
        rf_if.writeAddress  = 5'd0;
        rf_if.writeData     = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        test_reset();
        test_write_read();
        test_dual_read();
        test_x0();
        test_write_disable();
        test_bypass();
        test_back_to_back();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rv32_register_file.md
Name: rv32_register_file

Overview:
- RV32I integer register file: 32 x 32-bit architectural registers x0..x31, with two combinational read ports and one synchronous write port.
- Sits between instruction decode (rs1/rs2 reads) and writeback (rd write) in the core datapath.
- x0 is hardwired to zero.

Parameters:
- DATA_WIDTH, 32, width of each register and of the data ports.
- ADDR_WIDTH, 5, width of the register index; register count is 2**ADDR_WIDTH.

Ports:
- clk  input  1  single clock; all writes take effect on its rising edge.
- reset  input  1  asynchronous, active-high reset; clears all registers.
- r1Address  input  ADDR_WIDTH  read port 1 register index (rs1).
- r2Address  input  ADDR_WIDTH  read port 2 register index (rs2).
- r1Data  output  DATA_WIDTH  contents of register r1Address.
- r2Data  output  DATA_WIDTH  contents of register r2Address.
- writeRegister  input  1  write enable.
- writeAddress  input  ADDR_WIDTH  write register index (rd).
- writeData  input  DATA_WIDTH  data to write.

Behaviour:
- Clocking: one clock (clk). reset is asynchronous and active-high.
- Storage: 2**ADDR_WIDTH entries of DATA_WIDTH bits each.
- Reset:
  - While reset = 1, every entry is cleared to 0 immediately, without waiting for a clock edge.
  - r1Data and r2Data therefore read 0 for every address during reset.
  - Writes presented while reset = 1 are discarded.
- Write:
  - On the rising edge of clk with reset = 0 and writeRegister = 1, entry[writeAddress] <= writeData.
  - No write occurs when writeRegister = 0.
- x0:
  - A write to address 0 is ignored; entry 0 stays 0 permanently.
  - Reads of address 0 always return 0, regardless of any write attempt.
- Read:
  - Purely combinational; r1Data = entry[r1Address] and r2Data = entry[r2Address] with zero-cycle latency.
  - A change of address or a completed write is visible within the same cycle after settling.
  - Both ports may address the same register and must return identical values.
- Write latency: a written value is readable immediately after the active clk edge. Before that edge, the read returns the old value, unless the optional bypass below is compiled in.
- Simultaneous events:
  - A read of writeAddress during an enabled write cycle returns the pre-edge value; the new value appears after the edge.
  - Reset asserted on the same edge as a write wins; the entry stays 0.
  - Reset deasserted mid-cycle: the next enabled edge writes normally.
- Out-of-range addresses cannot occur; the index width exactly covers the register count.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined: each read port compares its address against writeAddress. When writeRegister = 1, reset = 0, writeAddress != 0 and the addresses match, the port outputs writeData combinationally in the same cycle, before the edge.
- Undefined: no bypass; reads reflect stored contents only, as described above.
- x0 reads return 0 in both builds.

Decomposition:
- Shared package rv32_regfile_pkg holds:
  - DATA_WIDTH and ADDR_WIDTH defaults.
  - NUM_REGS.
  - ZERO_REG index constant (0).
  - typedefs reg_addr_t (logic [ADDR_WIDTH-1:0]) and reg_data_t (logic [DATA_WIDTH-1:0]).
- One natural sub-module: rv32_regfile_read_port. It takes an address plus the storage array and, when bypass is enabled, the write-port signals; it produces the x0-forced, optionally bypassed read data. Instantiate it twice.

Test Plan:
- Reset pulse with all registers previously written -> all 32 addresses read 0 on both ports while reset = 1 and after release.
- reset = 0, write 0x000000FF to x5 (writeRegister = 1 for one edge), then set r1Address = 5 -> r1Data = 0x000000FF.
- Write 0x88888888 to x10, then r1Address = 5, r2Address = 10 -> r1Data = 0x000000FF, r2Data = 0x88888888 concurrently; with both ports at 10, both = 0x88888888.
- Write 0x11111111 to x0, then read address 0 on both ports -> both 0x00000000.
- writeRegister = 0 with writeAddress = 5, writeData = 0xDEADBEEF, clock edge -> x5 still 0x000000FF.
- Bypass: same-cycle write of 0xCAFEF00D to x7 with r1Address = 7, read before the edge:
  - REGFILE_WRITE_BYPASS_EN defined -> r1Data = 0xCAFEF00D.
  - Undefined -> old value; 0xCAFEF00D appears after the edge.
